risc_imem: RTL and testbench

- Program memory at the responder end of the fetch interface.
- Receives the 5-bit pc from the instruction unit and returns the 13-bit instruction word, which the instruction unit latches into its ir.
- Contains a 32x13 register-based store, plus a load port that fills the store sequentially over a valid/ready handshake.
- Returns nop (13'h0000) whenever no program is ready, so the free-running fetch/decode path executes nops during reset and load.

---
 rtl/risc_pkg.sv | 16 +
 rtl/risc_imem_loader.sv | 76 +++++++
 rtl/risc_imem.sv | 68 ++++++
 tb/tb_risc_imem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared fetch-path widths, nop encoding and program memory state encoding
package risc_pkg;

  localparam int IW    = 13;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  localparam logic [IW-1:0] NOP = 13'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_e;

endpackage

// File: rtl/risc_imem_loader.sv
// rtl/risc_imem_loader.sv - load sequencer: state, write pointer and word counter for the program store
module risc_imem_loader
  import risc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic          ld_last,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          clear,
  output logic          run,
  output logic          ld_ready,
  output logic [AW:0]   ld_count
);

  imem_state_e   state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   ld_count_q, ld_count_d;

  // State, pointer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      ld_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      ld_count_q <= ld_count_d;
    end
  end

  // Next-state logic; ld_start is only honoured outside LOAD, and a write
  // into the last slot ends the load even without ld_last
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    ld_count_d = ld_count_q;
    wr_en      = 1'b0;
    clear      = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (ld_start) begin
          state_d    = LOAD;
          wptr_d     = '0;
          ld_count_d = '0;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          wr_en      = 1'b1;
          wptr_d     = wptr_q + AW'(1);
          ld_count_d = ld_count_q + (AW+1)'(1);
          if (ld_last || (wptr_q == {AW{1'b1}})) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode only registered state so load inputs never reach them combinationally
  always_comb begin
    wr_addr  = wptr_q;
    ld_ready = (state_q == LOAD);
    run      = (state_q == RUN);
    ld_count = ld_count_q;
  end

endmodule

// File: rtl/risc_imem.sv
// rtl/risc_imem.sv - 32-word register program memory with sequential load port and zero-latency fetch read
module risc_imem
  import risc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  output logic [IW-1:0] instruction,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          prog_ready,
  output logic [AW:0]   ld_count
);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          clear;
  logic          run;

  risc_imem_loader u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_last  (ld_last),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .clear    (clear),
    .run      (run),
    .ld_ready (ld_ready),
    .ld_count (ld_count)
  );

  // Storage update: a new load wipes every word so unwritten slots read as nop
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = clear ? NOP : mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_addr] = ld_data;
    end
  end

  // Storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Unregistered read so the fetch unit latches mem[pc] on the same edge that advances pc
  always_comb begin
    instruction = run ? mem_q[pc] : NOP;
    prog_ready  = run;
  end

endmodule

// File: tb/tb_risc_imem.sv
// tb/tb_risc_imem.sv - directed self-checking bench for risc_imem
module tb_risc_imem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  pc;
  logic [12:0] instruction;
  logic        ld_start;
  logic        ld_valid;
  logic [12:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        prog_ready;
  logic [5:0]  ld_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  risc_imem dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instruction (instruction),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .prog_ready  (prog_ready),
    .ld_count    (ld_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc = '0; ld_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      pc = 5'(i);
      #1;
      checks++;
      if (instruction !== 13'h0000 || ld_ready !== 1'b0 || prog_ready !== 1'b0 || ld_count !== 6'd0) begin
        errors++;
        $display("FAIL reset_idle pc=%0d got instr=%h rdy=%b prog=%b cnt=%0d want 0000/0/0/0",
                 i, instruction, ld_ready, prog_ready, ld_count);
      end
      step();
    end
  endtask

  task automatic test_load3();
    logic [12:0] words [3];
    words[0] = 13'h1A01; words[1] = 13'h0B22; words[2] = 13'h1FFF;
    ld_start = 1; step(); ld_start = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ld_ready !== 1'b1 || prog_ready !== 1'b0 || instruction !== 13'h0000) begin
        errors++;
        $display("FAIL load3_ready beat=%0d got rdy=%b prog=%b instr=%h want 1/0/0000",
                 i, ld_ready, prog_ready, instruction);
      end
      ld_valid = 1; ld_data = words[i]; ld_last = (i == 2);
      step();
    end
    ld_valid = 0; ld_last = 0;
    checks++;
    if (prog_ready !== 1'b1 || ld_ready !== 1'b0 || ld_count !== 6'd3) begin
      errors++;
      $display("FAIL load3_done got prog=%b rdy=%b cnt=%0d want 1/0/3", prog_ready, ld_ready, ld_count);
    end
    for (int i = 0; i < 32; i++) begin
      pc = 5'(i);
      #1;
      checks++;
      if (instruction !== ((i < 3) ? words[i] : 13'h0000)) begin
        errors++;
        $display("FAIL load3_read pc=%0d got %h want %h", i, instruction, (i < 3) ? words[i] : 13'h0000);
      end
    end
  endtask

  task automatic test_gaps();
    logic        vpat [5];
    logic [12:0] dpat [5];
    logic [5:0]  cexp [5];
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 1;
    dpat[0] = 13'h0111; dpat[1] = 13'h0EEE; dpat[2] = 13'h0DDD; dpat[3] = 13'h0222; dpat[4] = 13'h0333;
    cexp[0] = 1; cexp[1] = 1; cexp[2] = 1; cexp[3] = 2; cexp[4] = 3;
    ld_start = 1; step(); ld_start = 0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = vpat[i]; ld_data = dpat[i]; ld_last = (i == 4);
      step();
      checks++;
      if (ld_count !== cexp[i]) begin
        errors++;
        $display("FAIL gaps_count cycle=%0d got %0d want %0d", i, ld_count, cexp[i]);
      end
    end
    ld_valid = 0; ld_last = 0;
    checks++;
    if (prog_ready !== 1'b1) begin
      errors++;
      $display("FAIL gaps_run got prog=%b want 1", prog_ready);
    end
    pc = 5'd0; #1; checks++;
    if (instruction !== 13'h0111) begin errors++; $display("FAIL gaps_w0 got %h want 0111", instruction); end
    pc = 5'd1; #1; checks++;
    if (instruction !== 13'h0222) begin errors++; $display("FAIL gaps_w1 got %h want 0222", instruction); end
    pc = 5'd2; #1; checks++;
    if (instruction !== 13'h0333) begin errors++; $display("FAIL gaps_w2 got %h want 0333", instruction); end
    pc = 5'd3; #1; checks++;
    if (instruction !== 13'h0000) begin errors++; $display("FAIL gaps_w3 got %h want 0000", instruction); end
  endtask

  task automatic test_full();
    ld_start = 1; step(); ld_start = 0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (ld_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_ready beat=%0d got %b want 1", i, ld_ready);
      end
      ld_valid = 1; ld_last = 0; ld_data = 13'(i) + 13'h100;
      step();
    end
    checks++;
    if (prog_ready !== 1'b1 || ld_count !== 6'd32 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_done got prog=%b cnt=%0d rdy=%b want 1/32/0", prog_ready, ld_count, ld_ready);
    end
    ld_data = 13'h1555;
    step();
    ld_valid = 0;
    checks++;
    if (ld_count !== 6'd32 || prog_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_extra got cnt=%0d prog=%b want 32/1", ld_count, prog_ready);
    end
    pc = 5'd0; #1; checks++;
    if (instruction !== 13'h0100) begin errors++; $display("FAIL full_pc0 got %h want 0100", instruction); end
    pc = 5'd17; #1; checks++;
    if (instruction !== 13'h0111) begin errors++; $display("FAIL full_pc17 got %h want 0111", instruction); end
    pc = 5'd31; #1; checks++;
    if (instruction !== 13'h011F) begin errors++; $display("FAIL full_pc31 got %h want 011F", instruction); end
  endtask

  task automatic test_reload();
    pc = 5'd1;
    ld_start = 1; ld_valid = 1; ld_data = 13'h0777; ld_last = 0;
    step();
    ld_start = 0; ld_valid = 0;
    checks++;
    if (prog_ready !== 1'b0 || instruction !== 13'h0000 || ld_count !== 6'd0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_start got prog=%b instr=%h cnt=%0d rdy=%b want 0/0000/0/1",
               prog_ready, instruction, ld_count, ld_ready);
    end
    ld_valid = 1; ld_data = 13'h0ABC; ld_last = 1;
    step();
    ld_valid = 0; ld_last = 0;
    checks++;
    if (prog_ready !== 1'b1 || ld_count !== 6'd1) begin
      errors++;
      $display("FAIL reload_done got prog=%b cnt=%0d want 1/1", prog_ready, ld_count);
    end
    pc = 5'd0; #1; checks++;
    if (instruction !== 13'h0ABC) begin errors++; $display("FAIL reload_pc0 got %h want 0ABC", instruction); end
    pc = 5'd1; #1; checks++;
    if (instruction !== 13'h0000) begin errors++; $display("FAIL reload_pc1 got %h want 0000", instruction); end
    pc = 5'd31; #1; checks++;
    if (instruction !== 13'h0000) begin errors++; $display("FAIL reload_pc31 got %h want 0000", instruction); end
  endtask

  task automatic test_async_reset();
    ld_start = 1; step(); ld_start = 0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1; ld_data = 13'h0040 + 13'(i); ld_last = 0;
      step();
    end
    ld_data = 13'h0042;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ld_ready !== 1'b0 || ld_count !== 6'd0 || prog_ready !== 1'b0 || instruction !== 13'h0000) begin
      errors++;
      $display("FAIL async_reset got rdy=%b cnt=%0d prog=%b instr=%h want 0/0/0/0000",
               ld_ready, ld_count, prog_ready, instruction);
    end
    ld_valid = 0;
    step();
    rst_n = 1'b1;
    ld_valid = 1; ld_last = 1; ld_data = 13'h0055;
    step(); step();
    ld_valid = 0; ld_last = 0;
    checks++;
    if (prog_ready !== 1'b0 || ld_ready !== 1'b0 || ld_count !== 6'd0) begin
      errors++;
      $display("FAIL async_idle got prog=%b rdy=%b cnt=%0d want 0/0/0", prog_ready, ld_ready, ld_count);
    end
    ld_start = 1; step(); ld_start = 0;
    ld_valid = 1; ld_data = 13'h0000; ld_last = 1;
    step();
    ld_valid = 0; ld_last = 0;
    checks++;
    if (prog_ready !== 1'b1 || ld_count !== 6'd1) begin
      errors++;
      $display("FAIL async_reload got prog=%b cnt=%0d want 1/1", prog_ready, ld_count);
    end
    for (int i = 0; i < 32; i++) begin
      pc = 5'(i);
      #1;
      checks++;
      if (instruction !== 13'h0000) begin
        errors++;
        $display("FAIL async_read pc=%0d got %h want 0000", i, instruction);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load3();
    test_gaps();
    test_full();
    test_reload();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
